// File: rtl/boids_fb_writer.sv
// Framebuffer write engine: streams draw-square and clear-frame palette writes into the pixel RAM.
// Optional: define BOIDS_FB_CLIP_EN to suppress writes of off-screen draw pixels.
module boids_fb_writer #(
  parameter int SIZE    = 4,
  parameter int WIDTH   = 640,
  parameter int HEIGHT  = 480,
  parameter int ADDR_W  = 20,
  parameter int COLOR_W = 9
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_op,
  input  logic [9:0]         cmd_x,
  input  logic [8:0]         cmd_y,
  input  logic [COLOR_W-1:0] cmd_color,
  output logic [ADDR_W-1:0]  fb_addr,
  output logic [COLOR_W-1:0] fb_wdata,
  output logic               fb_wen,
  output logic               busy,
  output logic               done
);

  localparam int                CNT_W      = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [CNT_W-1:0]  LAST_CNT   = CNT_W'(SIZE - 1);
  localparam logic [ADDR_W-1:0] WIDTH_A    = ADDR_W'(WIDTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(WIDTH * HEIGHT - 1);
  localparam logic [31:0]       WIDTH_BITS = 32'(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAW  = 2'd1,
    CLEAR = 2'd2
  } state_t;

  state_t              state_r;
  logic [9:0]          x0_r;
  logic [CNT_W-1:0]    col_r;
  logic [CNT_W-1:0]    row_r;
  logic [ADDR_W-1:0]   row_base_r;
`ifdef BOIDS_FB_CLIP_EN
  logic [8:0]          y0_r;
  logic [9:0]          nxt_y_s;
`endif

  logic                last_col_s;
  logic                last_row_s;
  logic [CNT_W-1:0]    nxt_col_s;
  logic [CNT_W-1:0]    nxt_row_s;
  logic [ADDR_W-1:0]   nxt_base_s;
  logic [10:0]         nxt_x_s;
  logic [ADDR_W-1:0]   nxt_addr_s;
  logic                nxt_wen_s;
  logic [ADDR_W-1:0]   acc_base_s;
  logic [ADDR_W-1:0]   acc_addr_s;
  logic                acc_wen_s;

  // Constant-coefficient y*WIDTH as a shift-add over the set bits of WIDTH.
  function automatic logic [ADDR_W-1:0] row_base_of(input logic [9:0] y);
    logic [ADDR_W-1:0] acc;
    acc = '0;
    for (int b = 0; b < 32; b++) begin
      if (WIDTH_BITS[b]) begin
        acc = acc + (ADDR_W'(y) << b);
      end else begin
        acc = acc;
      end
    end
    return acc;
  endfunction

  // Next draw pixel: column is the inner loop, the row base steps by WIDTH per row.
  always_comb begin
    last_col_s = (col_r == LAST_CNT);
    last_row_s = (row_r == LAST_CNT);
    if (last_col_s) begin
      nxt_col_s  = '0;
      nxt_row_s  = row_r + CNT_W'(1);
      nxt_base_s = row_base_r + WIDTH_A;
    end else begin
      nxt_col_s  = col_r + CNT_W'(1);
      nxt_row_s  = row_r;
      nxt_base_s = row_base_r;
    end
    nxt_x_s    = {1'b0, x0_r} + 11'(nxt_col_s);
    nxt_addr_s = nxt_base_s + ADDR_W'(nxt_x_s);
    acc_base_s = row_base_of({1'b0, cmd_y});
    acc_addr_s = acc_base_s + ADDR_W'(cmd_x);
`ifdef BOIDS_FB_CLIP_EN
    nxt_y_s    = {1'b0, y0_r} + 10'(nxt_row_s);
    nxt_wen_s  = (nxt_x_s < 11'(WIDTH)) && (nxt_y_s < 10'(HEIGHT));
    acc_wen_s  = ({1'b0, cmd_x} < 11'(WIDTH)) && ({1'b0, cmd_y} < 10'(HEIGHT));
`else
    nxt_wen_s  = 1'b1;
    acc_wen_s  = 1'b1;
`endif
  end

  // Command FSM with all outputs registered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= IDLE;
      x0_r       <= 10'd0;
`ifdef BOIDS_FB_CLIP_EN
      y0_r       <= 9'd0;
`endif
      col_r      <= '0;
      row_r      <= '0;
      row_base_r <= '0;
      cmd_ready  <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      fb_wen     <= 1'b0;
      fb_addr    <= '0;
      fb_wdata   <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          done   <= 1'b0;
          fb_wen <= 1'b0;
          if (cmd_valid) begin
            x0_r      <= cmd_x;
`ifdef BOIDS_FB_CLIP_EN
            y0_r      <= cmd_y;
`endif
            fb_wdata  <= cmd_color;
            col_r     <= '0;
            row_r     <= '0;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            if (cmd_op) begin
              state_r <= CLEAR;
              fb_addr <= '0;
              fb_wen  <= 1'b1;
            end else begin
              state_r    <= DRAW;
              row_base_r <= acc_base_s;
              fb_addr    <= acc_addr_s;
              fb_wen     <= acc_wen_s;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        DRAW: begin
          if (last_col_s && last_row_s) begin
            state_r   <= IDLE;
            fb_wen    <= 1'b0;
            done      <= 1'b1;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
          end else begin
            col_r      <= nxt_col_s;
            row_r      <= nxt_row_s;
            row_base_r <= nxt_base_s;
            fb_addr    <= nxt_addr_s;
            fb_wen     <= nxt_wen_s;
          end
        end
        CLEAR: begin
          if (fb_addr == LAST_ADDR) begin
            state_r   <= IDLE;
            fb_wen    <= 1'b0;
            done      <= 1'b1;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
          end else begin
            fb_addr <= fb_addr + ADDR_W'(1);
            fb_wen  <= 1'b1;
          end
        end
        default: begin
          state_r   <= IDLE;
          fb_wen    <= 1'b0;
          done      <= 1'b0;
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
